md_hilo_unit: RTL and testbench

Parametrised, multi-cycle multiply/divide unit that owns the HI/LO register pair for the CPU datapath. It is the successor to the single-cycle HI/LO block and sits beside the ALU in the execute stage. Differences from that block:
- Configurable data width.
- Pipelined multiply with parametrised latency.
- Radix-2 iterative divider.
- Multiply-accumulate (MADD/MSUB).
- A start/ready/done handshake the pipeline uses to stall, plus a flush input for exceptions.

---
 rtl/md_hilo_unit.sv | 196 +++++++++++++++++++
 tb/tb_md_hilo_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_hilo_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; MTHI/MTLO commit at acceptance, multiply ops after MUL_LAT cycles, divides after WIDTH cycles.
// ready is low while busy; start is ignored then (no queueing); flush returns to idle without committing.
module md_hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_Z} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, div0_q, div0_d;
  logic [3:0]         op_q, op_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;

  logic               accept, sgn_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_s, prod_u, acc_add, acc_sub;
  logic [WIDTH:0]     trial, diff;
  logic [WIDTH-1:0]   rem_nx, quo_nx, rem_fix, quo_fix;

  always_comb begin
    accept  = start && (state_q == S_IDLE) && !flush;
    sgn_div = (op == OP_DIV);
    a_mag   = (sgn_div && a[WIDTH-1]) ? -a : a;
    b_mag   = (sgn_div && b[WIDTH-1]) ? -b : b;
    prod_s  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    acc_add = {hi_q, lo_q} + prod_q;
    acc_sub = {hi_q, lo_q} - prod_q;
    // One restoring step: shift the next dividend bit into the partial remainder.
    trial   = {rem_q, quo_q[WIDTH-1]};
    diff    = trial - {1'b0, dvs_q};
    rem_nx  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nx  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    rem_fix = rneg_q ? -rem_nx : rem_nx;
    quo_fix = qneg_q ? -quo_nx : quo_nx;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;
    op_d    = op_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
              state_d = S_MUL;
              cnt_d   = '0;
              op_d    = op;
              prod_d  = (op == OP_MULTU) ? prod_u : prod_s;
            end
            OP_DIV, OP_DIVU: begin
              if (b == '0) begin
                state_d = S_Z;
              end else begin
                state_d = S_DIV;
                cnt_d   = '0;
                rem_d   = '0;
                quo_d   = a_mag;
                dvs_d   = b_mag;
                qneg_d  = sgn_div && (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg_d  = sgn_div && a[WIDTH-1];
              end
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == MUL_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          unique case (op_q)
            OP_MADD: {hi_d, lo_d} = acc_add;
            OP_MSUB: {hi_d, lo_d} = acc_sub;
            default: {hi_d, lo_d} = prod_q;
          endcase
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + CW'(1);
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (cnt_q == DIV_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          hi_d    = rem_fix;
          lo_d    = quo_fix;
        end
      end
      S_Z: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        div0_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything, including a commit due on this edge.
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      div0_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      op_q    <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
      op_q    <= op_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = done_q;
  assign div0  = div0_q;
  assign hi_o  = hi_q;
  assign lo_o  = lo_q;

endmodule

// File: tb/tb_md_hilo_unit.sv
// Scoreboard bench for md_hilo_unit at WIDTH=32, MUL_LAT=2: expected HI/LO/div0 and completion cycle queued at issue.
module tb_md_hilo_unit;

  localparam int W = 32;
  localparam int L = 2;

  logic         clk, rst_n, start, flush;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         ready, done, div0;
  logic [W-1:0] hi_o, lo_o;

  md_hilo_unit #(.WIDTH(W), .MUL_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .ready(ready), .done(done), .div0(div0),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t         sbq[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           done_cnt = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        exp_t e;
        done_cnt++;
        if (sbq.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'(0));
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("hi", 64'(hi_o), 64'(e.hi));
          chk("lo", 64'(lo_o), 64'(e.lo));
          chk("div0", 64'(div0), 64'(e.dz));
          chk("ready_with_done", 64'(ready), 64'(1));
        end
      end else if (div0) begin
        chk("div0_without_done", 64'(div0), 64'(0));
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'(0));
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int          n = 0;
    exp_t        e;
    longint      xs, ys, qs, rs;
    logic [63:0] p, r64, q64;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 64'(ready), 64'(1));
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    e.dz = 1'b0;
    case (o)
      4'd1, 4'd2, 4'd7, 4'd8: begin
        p = (o == 4'd2) ? ({32'd0, x} * {32'd0, y}) : 64'(xs * ys);
        if (o == 4'd7) p = {m_hi, m_lo} + p;
        if (o == 4'd8) p = {m_hi, m_lo} - p;
        e.hi = p[63:32]; e.lo = p[31:0]; e.cyc = cyc + L;
        chk("busy_mul", 64'(ready), 64'(0));
        sbq.push_back(e);
      end
      4'd3, 4'd4: begin
        if (y == '0) begin
          e.hi = m_hi; e.lo = m_lo; e.dz = 1'b1; e.cyc = cyc + 1;
        end else begin
          if (o == 4'd4) begin
            q64 = {32'd0, x / y};
            r64 = {32'd0, x % y};
          end else begin
            qs = xs / ys; rs = xs % ys;
            q64 = 64'(qs); r64 = 64'(rs);
          end
          e.hi = r64[31:0]; e.lo = q64[31:0]; e.cyc = cyc + W;
        end
        chk("busy_div", 64'(ready), 64'(0));
        sbq.push_back(e);
      end
      4'd5: begin
        chk("mthi", 64'(hi_o), 64'(x));
        chk("mthi_no_done", 64'(done), 64'(0));
        e.hi = x; e.lo = m_lo;
      end
      4'd6: begin
        chk("mtlo", 64'(lo_o), 64'(x));
        chk("mtlo_ready", 64'(ready), 64'(1));
        e.hi = m_hi; e.lo = x;
      end
      default: begin
        e.hi = m_hi; e.lo = m_lo;
      end
    endcase
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [3:0] ops [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_div0", 64'(div0), 64'(0));
    chk("rst_hi", 64'(hi_o), 64'(0));
    chk("rst_lo", 64'(lo_o), 64'(0));
    rst_n = 1'b1;

    issue(4'd1, 32'hFFFF_FFFD, 32'd7);
    wait_drain();
    chk("mult_hi_const", 64'(hi_o), 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo_const", 64'(lo_o), 64'h0000_0000_FFFF_FFEB);
    issue(4'd2, 32'hFFFF_FFFD, 32'd7);
    wait_drain();
    chk("multu_hi_const", 64'(hi_o), 64'h6);

    issue(4'd4, 32'd100, 32'd7);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_drain();
    chk("div_ovf_lo_const", 64'(lo_o), 64'h8000_0000);
    chk("div_ovf_hi_const", 64'(hi_o), 64'h0);

    issue(4'd5, 32'h11, 32'd0);
    issue(4'd6, 32'h22, 32'd0);
    issue(4'd3, 32'd5, 32'd0);
    wait_drain();
    chk("div0_hi_kept", 64'(hi_o), 64'h11);

    issue(4'd5, 32'h0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    issue(4'd7, 32'd1, 32'd1);
    wait_drain();
    chk("madd_hi_const", 64'(hi_o), 64'h1);
    chk("madd_lo_const", 64'(lo_o), 64'h0);
    issue(4'd8, 32'd1, 32'd1);
    wait_drain();
    chk("msub_lo_const", 64'(lo_o), 64'hFFFF_FFFF);

    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] rb;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      issue(ops[$urandom_range(0, 5)], $urandom, rb);
    end
    issue(4'd0, 32'h1234, 32'd1);
    issue(4'd12, 32'h1234, 32'd1);
    wait_drain();
    chk("nop_hi", 64'(hi_o), 64'(m_hi));
    chk("nop_lo", 64'(lo_o), 64'(m_lo));

    // DIVU flushed mid-flight while start stays high with an MTHI behind it.
    @(negedge clk);
    start = 1'b1; op = 4'd4; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1;
    op = 4'd5; a = 32'hDEAD_BEEF;
    chk("flush_busy", 64'(ready), 64'(0));
    d0 = done_cnt;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_ready", 64'(ready), 64'(1));
    chk("flush_hi", 64'(hi_o), 64'(m_hi));
    chk("flush_lo", 64'(lo_o), 64'(m_lo));
    repeat (40) @(negedge clk);
    chk("flush_no_done", 64'(done_cnt), 64'(d0));
    chk("flush_hi_late", 64'(hi_o), 64'(m_hi));

    @(negedge clk);
    start = 1'b1; op = 4'd5; a = 32'h0000_BEEF; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_beats_start", 64'(hi_o), 64'(m_hi));

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 4'd4; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(ready), 64'(1));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_hi", 64'(hi_o), 64'(0));
    chk("arst_lo", 64'(lo_o), 64'(0));
    m_hi = '0; m_lo = '0;
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("arst_no_done", 64'(done_cnt), 64'(d0));

    issue(4'd1, 32'd6, 32'd7);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
